// File: rtl/alu_seq_wide_if.sv
// Bus bundle for alu_seq_wide: request/operand inputs plus result and 6502-style flags.
// The master modport is the requester side and the slave modport is the ALU side.
interface alu_seq_wide_if #(parameter int WIDTH = 16) ();
    logic             rdy;
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             bcd;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             co;
    logic             v;
    logic             z;
    logic             n;
    logic             hc;

    modport master (
        output rdy, start, op, a, b, ci, bcd,
        input  busy, done, out, co, v, z, n, hc
    );

    modport slave (
        input  rdy, start, op, a, b, ci, bcd,
        output busy, done, out, co, v, z, n, hc
    );
endinterface

// File: rtl/alu_seq_wide.sv
// Multi-nibble sequential ALU: NPC nibbles per clock, LSB nibble first, ripple carry across cycles.
// Define ALU_BCD_EN to build decimal correction for ADD/SUB; otherwise the bcd input is ignored.
module alu_seq_wide #(
    parameter int WIDTH = 16,
    parameter int NPC   = 1
) (
    input  logic         clk,
    input  logic         reset,
    alu_seq_wide_if.slave bus
);
    localparam int K  = WIDTH / (4 * NPC);
    localparam int SW = 4 * NPC;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int RW = (K > 1) ? (WIDTH - SW) : 1;

    localparam logic [2:0] OP_OR   = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_PASS = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_ASL  = 3'd6;
    localparam logic [2:0] OP_ROR  = 3'd7;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nx;
    logic [2:0]       op_q;
    logic [WIDTH:0]   a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic             a0_q;
    logic             hc_q;
    logic [CW-1:0]    cnt;
    logic [RW-1:0]    res_q;
    logic [WIDTH-1:0] out_q;
    logic             co_q, v_q, n_q, hc_out_q, done_q;

    logic             accept, step_en, last_step;
    logic [2:0]       op_in;
    logic [SW-1:0]    digits;
    logic             chain_out, hc_step, v_step;
    logic [WIDTH-1:0] new_res;
    logic             is_arith, co_final, v_final, hc_final;

`ifdef ALU_BCD_EN
    logic             bcd_q;
`else
    logic             unused_bcd;
    assign unused_bcd = bus.bcd;
`endif

    assign op_in    = bus.op[3] ? OP_PASS : bus.op[2:0];
    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // A start on the final step edge chains straight into the next operation.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = RUN;
            RUN:  if (step_en && last_step && !accept) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        step_en   = (state == RUN) && bus.rdy;
        last_step = (cnt == CW'(K - 1));
        accept    = bus.rdy && bus.start && ((state == IDLE) || ((state == RUN) && last_step));
    end

    always_comb begin
        logic [3:0] an, bn, bx, dig;
        logic [4:0] sum;
        logic       nx, c, cn;
        c       = carry_q;
        digits  = '0;
        hc_step = 1'b0;
        v_step  = 1'b0;
        for (int j = 0; j < NPC; j++) begin
            an  = a_q[4*j +: 4];
            bn  = b_q[4*j +: 4];
            nx  = a_q[4*j + 4];
            bx  = (op_q == OP_SUB) ? ~bn : bn;
            sum = {1'b0, an} + {1'b0, bx} + {4'b0000, c};
            cn  = sum[4];
            dig = an;
            case (op_q)
                OP_OR:  dig = an | bn;
                OP_AND: dig = an & bn;
                OP_XOR: dig = an ^ bn;
                OP_ADD, OP_SUB: begin
                    dig = sum[3:0];
`ifdef ALU_BCD_EN
                    if (bcd_q) begin
                        if (op_q == OP_ADD) begin
                            if (sum > 5'd9) begin
                                dig = sum[3:0] + 4'd6;
                                cn  = 1'b1;
                            end
                        end else if (!sum[4]) begin
                            dig = sum[3:0] - 4'd6;
                        end
                    end
`endif
                    // Overflow always uses the uncorrected binary msb of the top nibble.
                    if (j == NPC - 1) v_step = (an[3] == bx[3]) && (sum[3] != an[3]);
                    if (j == 0)       hc_step = cn;
                    c = cn;
                end
                OP_ASL: begin
                    dig = {an[2:0], c};
                    c   = an[3];
                end
                OP_ROR:  dig = {nx, an[3:1]};
                default: dig = an;
            endcase
            digits[4*j +: 4] = dig;
        end
        chain_out = c;
    end

    generate
        if (K > 1) begin : g_multi
            assign new_res = {digits, res_q};
        end else begin : g_single
            assign new_res = digits;
        end
    endgenerate

    always_comb begin
        case (op_q)
            OP_ADD, OP_SUB, OP_ASL: co_final = chain_out;
            OP_ROR:                 co_final = a0_q;
            default:                co_final = 1'b0;
        endcase
        v_final  = is_arith && v_step;
        hc_final = is_arith && ((cnt == '0) ? hc_step : hc_q);
    end

    // Working registers shift right each step; an accept on the final step overrides them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= OP_OR;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            a0_q     <= 1'b0;
            hc_q     <= 1'b0;
            cnt      <= '0;
            res_q    <= '0;
            out_q    <= '0;
            co_q     <= 1'b0;
            v_q      <= 1'b0;
            n_q      <= 1'b0;
            hc_out_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef ALU_BCD_EN
            bcd_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (step_en) begin
                res_q   <= new_res[WIDTH-1:WIDTH-RW];
                a_q     <= a_q >> SW;
                b_q     <= b_q >> SW;
                carry_q <= chain_out;
                cnt     <= cnt + CW'(1);
                if (cnt == '0) hc_q <= hc_step;
                if (last_step) begin
                    out_q    <= new_res;
                    co_q     <= co_final;
                    v_q      <= v_final;
                    n_q      <= new_res[WIDTH-1];
                    hc_out_q <= hc_final;
                    done_q   <= 1'b1;
                    cnt      <= '0;
                end
            end
            if (accept) begin
                op_q    <= op_in;
                a_q     <= {bus.ci, bus.a};
                b_q     <= bus.b;
                a0_q    <= bus.a[0];
                carry_q <= ((op_in == OP_ADD) || (op_in == OP_SUB) || (op_in == OP_ASL)) ? bus.ci : 1'b0;
                cnt     <= '0;
`ifdef ALU_BCD_EN
                bcd_q   <= bus.bcd;
`endif
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = done_q;
    assign bus.out  = out_q;
    assign bus.co   = co_q;
    assign bus.v    = v_q;
    assign bus.n    = n_q;
    assign bus.hc   = hc_out_q;
    assign bus.z    = (out_q == '0);
endmodule

// File: tb/tb_alu_seq_wide.sv
// Scoreboard bench for alu_seq_wide (WIDTH=16, NPC=1); BCD expectations follow ALU_BCD_EN.
// Expected results are queued at accept time and a negedge monitor checks them on each done.
module tb_alu_seq_wide;
    localparam int WIDTH = 16;

    localparam logic [3:0] OP_OR  = 4'b0000;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0101;
    localparam logic [3:0] OP_ASL = 4'b0110;
    localparam logic [3:0] OP_ROR = 4'b0111;
    localparam logic [3:0] OP_HI  = 4'b1010;

    typedef struct {
        string       name;
        logic [15:0] out;
        logic        co;
        logic        v;
        logic        hc;
        logic [2:0]  mask;
        int          acc_cyc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_compared = 0;
    int   n_failed = 0;
    exp_t sb[$];

    alu_seq_wide_if #(.WIDTH(WIDTH)) bus ();

    alu_seq_wide #(.WIDTH(WIDTH), .NPC(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_compared++;
        if (act !== expv) begin
            n_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: every done pops one expectation; mask selects co/v/hc checks.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && bus.done) begin
            if (sb.size() == 0) begin
                check_output("spurious_done", {31'd0, bus.done}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_output({e.name, "_out"}, {16'd0, bus.out}, {16'd0, e.out});
                check_output({e.name, "_n"}, {31'd0, bus.n}, {31'd0, e.out[15]});
                check_output({e.name, "_z"}, {31'd0, bus.z}, {31'd0, (e.out == 16'h0000)});
                if (e.mask[0]) check_output({e.name, "_co"}, {31'd0, bus.co}, {31'd0, e.co});
                if (e.mask[1]) check_output({e.name, "_v"}, {31'd0, bus.v}, {31'd0, e.v});
                if (e.mask[2]) check_output({e.name, "_hc"}, {31'd0, bus.hc}, {31'd0, e.hc});
                check_output({e.name, "_lat"}, cyc - e.acc_cyc + 1, e.lat);
            end
        end
    end

    task automatic drive_start(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                               input logic ci, input logic bcd);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.ci    = ci;
        bus.bcd   = bcd;
        bus.start = 1'b1;
    endtask

    task automatic push_exp(input string name, input logic [15:0] out, input logic co, input logic v,
                            input logic hc, input logic [2:0] mask, input int lat);
        exp_t e;
        e.name    = name;
        e.out     = out;
        e.co      = co;
        e.v       = v;
        e.hc      = hc;
        e.mask    = mask;
        e.acc_cyc = cyc;
        e.lat     = lat;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check_output("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    task automatic apply_stimulus(input string name, input logic [3:0] op, input logic [15:0] a,
                                  input logic [15:0] b, input logic ci, input logic bcd,
                                  input logic [15:0] out, input logic co, input logic v,
                                  input logic hc, input logic [2:0] mask);
        @(negedge clk);
        drive_start(op, a, b, ci, bcd);
        @(negedge clk);
        bus.start = 1'b0;
        push_exp(name, out, co, v, hc, mask, 5);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        bus.rdy   = 1'b1;
        bus.start = 1'b0;
        bus.op    = 4'd0;
        bus.a     = 16'd0;
        bus.b     = 16'd0;
        bus.ci    = 1'b0;
        bus.bcd   = 1'b0;
        repeat (2) @(negedge clk);

        check_output("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_output("rst_done", {31'd0, bus.done}, 32'd0);
        check_output("rst_out", {16'd0, bus.out}, 32'd0);
        check_output("rst_co", {31'd0, bus.co}, 32'd0);
        check_output("rst_v", {31'd0, bus.v}, 32'd0);
        check_output("rst_n", {31'd0, bus.n}, 32'd0);
        check_output("rst_hc", {31'd0, bus.hc}, 32'd0);
        check_output("rst_z", {31'd0, bus.z}, 32'd1);
        reset = 1'b0;

        apply_stimulus("add_bin", OP_ADD, 16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b1, 3'b111);
        apply_stimulus("sub_bin", OP_SUB, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 3'b111);
        apply_stimulus("asl", OP_ASL, 16'h8000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'b001);
`ifdef ALU_BCD_EN
        apply_stimulus("bcd_add", OP_ADD, 16'h0999, 16'h0001, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b1, 3'b111);
        apply_stimulus("bcd_sub", OP_SUB, 16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0999, 1'b1, 1'b0, 1'b0, 3'b111);
`else
        apply_stimulus("bcd_add", OP_ADD, 16'h0999, 16'h0001, 1'b0, 1'b1, 16'h099A, 1'b0, 1'b0, 1'b0, 3'b111);
        apply_stimulus("bcd_sub", OP_SUB, 16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0FFF, 1'b1, 1'b0, 1'b0, 3'b111);
`endif
        apply_stimulus("ror", OP_ROR, 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0, 3'b001);
        apply_stimulus("and", OP_AND, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0, 3'b111);
        apply_stimulus("or", OP_OR, 16'h1200, 16'h0034, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 3'b111);
        apply_stimulus("xor", OP_XOR, 16'hFFFF, 16'h0F0F, 1'b0, 1'b0, 16'hF0F0, 1'b0, 1'b0, 1'b0, 3'b111);
        apply_stimulus("op_hi", OP_HI, 16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hABCD, 1'b0, 1'b0, 1'b0, 3'b111);
        apply_stimulus("add_wrap", OP_ADD, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 3'b111);
        apply_stimulus("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 3'b111);

        // rdy low for three edges after the first step stretches latency to 8
        @(negedge clk);
        drive_start(OP_ADD, 16'h0001, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        push_exp("stall", 16'h0002, 1'b0, 1'b0, 1'b0, 3'b111, 8);
        @(negedge clk);
        bus.rdy = 1'b0;
        repeat (2) @(negedge clk);
        check_output("stall_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        bus.rdy = 1'b1;
        wait_idle();

        // a start pulse while busy must not produce a second done
        @(negedge clk);
        drive_start(OP_ADD, 16'h0005, 16'h0003, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        push_exp("busy_ign", 16'h0008, 1'b0, 1'b0, 1'b0, 3'b111, 5);
        @(negedge clk);
        drive_start(OP_OR, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        repeat (8) @(negedge clk);
        check_output("busy_ign_idle", {31'd0, bus.busy}, 32'd0);

        // start held on the edge the first done rises chains a second operation
        @(negedge clk);
        drive_start(OP_ADD, 16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        push_exp("b2b_first", 16'h3333, 1'b0, 1'b0, 1'b0, 3'b111, 5);
        repeat (3) @(negedge clk);
        drive_start(OP_SUB, 16'h0005, 16'h0007, 1'b1, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        check_output("b2b_busy", {31'd0, bus.busy}, 32'd1);
        push_exp("b2b_second", 16'hFFFE, 1'b0, 1'b0, 1'b0, 3'b111, 5);
        wait_idle();

        // reset mid-operation: immediate clear, aborted op never reports done
        @(negedge clk);
        drive_start(OP_ADD, 16'h1234, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check_output("midrst_out", {16'd0, bus.out}, 32'd0);
        check_output("midrst_z", {31'd0, bus.z}, 32'd1);
        check_output("midrst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check_output("midrst_idle", {31'd0, bus.busy}, 32'd0);

`ifdef ALU_BCD_EN
        apply_stimulus("bcd_digit", OP_ADD, 16'h0009, 16'h0001, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b1, 3'b111);
`else
        apply_stimulus("bcd_digit", OP_ADD, 16'h0009, 16'h0001, 1'b0, 1'b1, 16'h000A, 1'b0, 1'b0, 1'b0, 3'b111);
`endif

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end
endmodule
